sonar_io_bridge: RTL and testbench

- Parametrised memory-mapped I/O bridge between the processor data-memory port and the data RAM.
- Routes accesses below `IO_BASE` to RAM unchanged; decodes accesses at or above `IO_BASE` into an LED register, a free-running cycle counter and `NUM_CH` independent sonar channels.
- Each sonar channel emits a trigger pulse and measures echo pulse width in clock cycles.
- Replaces direct wiring of `memAddr` to the LEDs and raw `io_pins` handling in the top-level FPGA wrapper.

---
 rtl/sonar_io_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_sonar_io_bridge.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_io_bridge.sv
// Memory-mapped I/O bridge: RAM pass-through below IO_BASE, LED/CTRL/STATUS/CYCLE/WIDTH above it.
// Optional per-measurement timeout is enabled by defining SONAR_TIMEOUT_EN.
module sonar_io_bridge #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 24,
   parameter int unsigned TRIG_CYC = 500,
   parameter logic [11:0] IO_BASE  = 12'hF00,
   parameter int unsigned TIMEOUT  = 2400000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wren,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   output logic [31:0]       q_dmem,
   output logic              ram_wEn,
   output logic [11:0]       ram_addr,
   output logic [31:0]       ram_dataIn,
   input  logic [31:0]       ram_dataOut,
   output logic [NUM_CH-1:0] trig,
   input  logic [NUM_CH-1:0] echo,
   output logic [7:0]        led
);

   localparam int unsigned TW = (TRIG_CYC > 1) ? $clog2(TRIG_CYC) : 1;

   typedef enum logic [2:0] {StIdle, StTrig, StWaitRise, StMeasure, StDone} ch_state_e;

   logic [11:0]       off;
   logic              io_sel, io_wr, io_rd;
   logic [NUM_CH-1:0] start, rd_clr;
   logic [31:0]       io_rdata;

   logic              io_sel_q;
   logic [31:0]       io_rdata_q;
   logic [7:0]        led_q;
   logic [CNT_W-1:0]  cyc_q;
   logic [NUM_CH-1:0] echo_m_q, echo_s_q;
   logic [NUM_CH-1:0] done_q, done_d, to_q, to_d;

   ch_state_e         state_q [NUM_CH];
   ch_state_e         state_d [NUM_CH];
   logic [TW-1:0]     tcnt_q  [NUM_CH];
   logic [TW-1:0]     tcnt_d  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [CNT_W-1:0]  width_q [NUM_CH];
   logic [CNT_W-1:0]  width_d [NUM_CH];

`ifdef SONAR_TIMEOUT_EN
   localparam int unsigned TOW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TOW-1:0]    tocnt_q [NUM_CH];
   logic [TOW-1:0]    tocnt_d [NUM_CH];
`else
   logic              unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   logic unused_addr;
   assign unused_addr = ^address_dmem[31:12];

   assign io_sel     = address_dmem[11:0] >= IO_BASE;
   assign off        = address_dmem[11:0] - IO_BASE;
   assign io_wr      = wren & io_sel;
   // Every non-store cycle is treated as a load, so address decode alone drives read side effects.
   assign io_rd      = ~wren & io_sel;
   assign ram_wEn    = wren & ~io_sel;
   assign ram_addr   = address_dmem[11:0];
   assign ram_dataIn = data;
   assign start      = (io_wr && off == 12'h001) ? data[NUM_CH-1:0] : '0;
   assign led        = led_q;
   assign q_dmem     = io_sel_q ? io_rdata_q : ram_dataOut;

   always_comb begin
      io_rdata = '0;
      rd_clr   = '0;
      if (off == 12'h000) begin
         io_rdata[7:0] = led_q;
      end else if (off == 12'h002) begin
         io_rdata[NUM_CH-1:0]  = done_q;
         io_rdata[16 +: NUM_CH] = to_q;
      end else if (off == 12'h003) begin
         io_rdata[CNT_W-1:0] = cyc_q;
      end
      for (int n = 0; n < NUM_CH; n++) begin
         if (off == 12'(16 + n)) begin
            io_rdata[CNT_W-1:0] = width_q[n];
            rd_clr[n]           = io_rd;
         end
      end
   end

   always_comb begin
      for (int n = 0; n < NUM_CH; n++) begin
         trig[n] = (state_q[n] == StTrig);
      end
   end

   always_comb begin
      done_d = done_q;
      to_d   = to_q;
      for (int n = 0; n < NUM_CH; n++) begin
         state_d[n] = state_q[n];
         tcnt_d[n]  = tcnt_q[n];
         cnt_d[n]   = cnt_q[n];
         width_d[n] = width_q[n];
         // Clears come first so a same-cycle completion can set the flag again.
         if (rd_clr[n]) begin
            done_d[n] = 1'b0;
            to_d[n]   = 1'b0;
         end
         case (state_q[n])
            StIdle, StDone: begin
               if (start[n]) begin
                  state_d[n] = StTrig;
                  tcnt_d[n]  = '0;
                  cnt_d[n]   = '0;
                  done_d[n]  = 1'b0;
                  to_d[n]    = 1'b0;
               end
            end
            StTrig: begin
               if (tcnt_q[n] == TW'(TRIG_CYC - 1)) begin
                  state_d[n] = StWaitRise;
               end else begin
                  tcnt_d[n] = tcnt_q[n] + 1'b1;
               end
            end
            StWaitRise: begin
               if (echo_s_q[n]) begin
                  state_d[n] = StMeasure;
                  cnt_d[n]   = CNT_W'(1);
               end
            end
            StMeasure: begin
               if (echo_s_q[n]) begin
                  if (cnt_q[n] != {CNT_W{1'b1}}) cnt_d[n] = cnt_q[n] + 1'b1;
               end else begin
                  width_d[n] = cnt_q[n];
                  done_d[n]  = 1'b1;
                  state_d[n] = StDone;
               end
            end
            default: state_d[n] = StIdle;
         endcase
`ifdef SONAR_TIMEOUT_EN
         tocnt_d[n] = tocnt_q[n];
         if (state_q[n] == StTrig) begin
            tocnt_d[n] = '0;
         end else if (state_q[n] == StWaitRise || state_q[n] == StMeasure) begin
            if (tocnt_q[n] == TOW'(TIMEOUT - 1)) begin
               state_d[n] = StDone;
               width_d[n] = '1;
               done_d[n]  = 1'b1;
               to_d[n]    = 1'b1;
            end else begin
               tocnt_d[n] = tocnt_q[n] + 1'b1;
            end
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         // Select I/O with zero data so q_dmem reads 0 straight out of reset.
         io_sel_q   <= 1'b1;
         io_rdata_q <= '0;
         led_q      <= '0;
         cyc_q      <= '0;
         echo_m_q   <= '0;
         echo_s_q   <= '0;
         done_q     <= '0;
         to_q       <= '0;
         for (int n = 0; n < NUM_CH; n++) begin
            state_q[n] <= StIdle;
            tcnt_q[n]  <= '0;
            cnt_q[n]   <= '0;
            width_q[n] <= '0;
         end
      end else begin
         io_sel_q   <= io_sel;
         io_rdata_q <= io_rdata;
         if (io_wr && off == 12'h000) led_q <= data[7:0];
         cyc_q      <= cyc_q + 1'b1;
         echo_m_q   <= echo;
         echo_s_q   <= echo_m_q;
         done_q     <= done_d;
         to_q       <= to_d;
         for (int n = 0; n < NUM_CH; n++) begin
            state_q[n] <= state_d[n];
            tcnt_q[n]  <= tcnt_d[n];
            cnt_q[n]   <= cnt_d[n];
            width_q[n] <= width_d[n];
         end
      end
   end

`ifdef SONAR_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int n = 0; n < NUM_CH; n++) tocnt_q[n] <= '0;
      end else begin
         for (int n = 0; n < NUM_CH; n++) tocnt_q[n] <= tocnt_d[n];
      end
   end
`endif

endmodule

// File: tb/tb_sonar_io_bridge.sv
// Directed bench for sonar_io_bridge: vector table for the bus decode plus sonar sequences.
module tb_sonar_io_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic        wren;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic [31:0] q_dmem;
   logic        ram_wEn;
   logic [11:0] ram_addr;
   logic [31:0] ram_dataIn;
   logic [31:0] ram_dataOut;
   logic [3:0]  trig;
   logic [3:0]  echo;
   logic [7:0]  led;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [4096];

   always #5 clock = ~clock;

   sonar_io_bridge #(
      .NUM_CH   (4),
      .CNT_W    (24),
      .TRIG_CYC (10),
      .IO_BASE  (12'hF00),
      .TIMEOUT  (50)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .wren         (wren),
      .address_dmem (address_dmem),
      .data         (data),
      .q_dmem       (q_dmem),
      .ram_wEn      (ram_wEn),
      .ram_addr     (ram_addr),
      .ram_dataIn   (ram_dataIn),
      .ram_dataOut  (ram_dataOut),
      .trig         (trig),
      .echo         (echo),
      .led          (led)
   );

   // Synchronous-read RAM model, one cycle of latency.
   always @(posedge clock) begin
      if (ram_wEn) mem[ram_addr] <= ram_dataIn;
      ram_dataOut <= mem[ram_addr];
   end

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk_q;
      logic [31:0] exp_q;
      logic [7:0]  exp_led;
      logic        exp_wen;
   } vec_t;

   vec_t vecs [17];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_rng(input string name, input logic [31:0] act, input logic [31:0] lo,
                          input logic [31:0] hi);
      checks++;
      if ($isunknown(act) || act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      wren = 1'b1;
      address_dmem = a;
      data = d;
      tick();
      wren = 1'b0;
      address_dmem = 32'h0;
      data = 32'h0;
   endtask

   // Parks the address on RAM afterwards so a held WIDTH address does not keep clearing flags.
   task automatic load(input logic [31:0] a, output logic [31:0] q);
      wren = 1'b0;
      address_dmem = a;
      tick();
      q = q_dmem;
      address_dmem = 32'h0;
   endtask

   initial begin
      logic [31:0] rd;
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      reset = 1'b1;
      wren = 1'b0;
      address_dmem = 32'hF03;
      data = 32'h0;
      echo = 4'h0;

      vecs[0]  = '{1'b1, 32'h0000_0F00, 32'h0000_00A5, 1'b0, 32'h0,          8'hA5, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0F00, 32'h0,          1'b1, 32'h0000_00A5, 8'hA5, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_1234, 1'b0, 32'h0,          8'hA5, 1'b1};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'h0000_1234, 8'hA5, 1'b0};
      vecs[4]  = '{1'b1, 32'h0000_0011, 32'hFFFF_FF3C, 1'b0, 32'h0,          8'hA5, 1'b1};
      vecs[5]  = '{1'b0, 32'h0000_0011, 32'h0,          1'b1, 32'hFFFF_FF3C, 8'hA5, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,          1'b1, 32'h0000_1234, 8'hA5, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0F05, 32'hFFFF_FFFF, 1'b0, 32'h0,          8'hA5, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0F05, 32'h0,          1'b1, 32'h0,          8'hA5, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0F02, 32'h0,          1'b1, 32'h0,          8'hA5, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0F10, 32'h0,          1'b1, 32'h0,          8'hA5, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_1F00, 32'h0001_FF5A, 1'b0, 32'h0,          8'h5A, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0F00, 32'h0,          1'b1, 32'h0000_005A, 8'h5A, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_0F02, 32'hFFFF_FFFF, 1'b0, 32'h0,          8'h5A, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0F02, 32'h0,          1'b1, 32'h0,          8'h5A, 1'b0};
      vecs[15] = '{1'b1, 32'h0000_0EFF, 32'h0000_0077, 1'b0, 32'h0,          8'h5A, 1'b1};
      vecs[16] = '{1'b0, 32'h0000_0EFF, 32'h0,          1'b1, 32'h0000_0077, 8'h5A, 1'b0};

      // Reset state.
      repeat (3) tick();
      chk("reset_trig", {28'h0, trig}, 32'h0);
      chk("reset_led", {24'h0, led}, 32'h0);
      chk("reset_q", q_dmem, 32'h0);
      chk("reset_wen", {31'h0, ram_wEn}, 32'h0);
      reset = 1'b0;
      tick();
      chk("cycle_first", q_dmem, 32'h0);
      tick();
      chk("cycle_second", q_dmem, 32'h1);
      address_dmem = 32'h0;
      tick();

      // Bus decode vectors.
      for (int i = 0; i < 17; i++) begin
         wren = vecs[i].wr;
         address_dmem = vecs[i].addr;
         data = vecs[i].wdata;
         #1;
         chk($sformatf("vec%0d_wen", i), {31'h0, ram_wEn}, {31'h0, vecs[i].exp_wen});
         tick();
         if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
         chk($sformatf("vec%0d_led", i), {24'h0, led}, {24'h0, vecs[i].exp_led});
      end
      wren = 1'b0;
      address_dmem = 32'h0;
      data = 32'h0;

      // Channel 0 single measurement.
      store(32'hF01, 32'h1);
      chk("ch0_trig_others", {28'h0, trig & 4'hE}, 32'h0);
      n = 0;
      while (trig[0] && n < 50) begin
         n++;
         tick();
      end
      chk("ch0_trig_len", n, 32'd10);
      repeat (10) tick();
      echo[0] = 1'b1;
      repeat (100) tick();
      echo[0] = 1'b0;
      repeat (4) tick();
      load(32'hF02, rd);
      chk("ch0_status", rd, 32'h1);
      load(32'hF10, rd);
      chk_rng("ch0_width", rd, 99, 101);
      load(32'hF02, rd);
      chk("ch0_status_clr", rd, 32'h0);

      // Restart channel 0, then request 0 and 1 while 0 is busy.
      store(32'hF01, 32'h1);
      load(32'hF10, rd);
      chk_rng("ch0_width_held", rd, 99, 101);
      repeat (11) tick();
      echo[0] = 1'b1;
      repeat (5) tick();
      store(32'hF01, 32'h3);
      chk("busy_trig1", {31'h0, trig[1]}, 32'h1);
      chk("busy_trig0", {31'h0, trig[0]}, 32'h0);
      repeat (24) tick();
      echo[0] = 1'b0;
      echo[1] = 1'b1;
      repeat (40) tick();
      echo[1] = 1'b0;
      repeat (4) tick();
      load(32'hF02, rd);
      chk("busy_status", rd, 32'h3);
      load(32'hF10, rd);
      chk_rng("busy_width0", rd, 29, 31);
      load(32'hF02, rd);
      chk("busy_status_after0", rd, 32'h2);
      load(32'hF11, rd);
      chk_rng("busy_width1", rd, 39, 41);
      load(32'hF02, rd);
      chk("busy_status_after1", rd, 32'h0);

      // Channel 2: complete once, restart, reset mid-measure, then measure again.
      store(32'hF01, 32'h4);
      repeat (12) tick();
      echo[2] = 1'b1;
      repeat (20) tick();
      echo[2] = 1'b0;
      repeat (4) tick();
      store(32'hF00, 32'h77);
      store(32'hF01, 32'h4);
      repeat (12) tick();
      echo[2] = 1'b1;
      repeat (10) tick();
      reset = 1'b1;
      tick();
      chk("rst_mid_trig", {28'h0, trig}, 32'h0);
      chk("rst_mid_led", {24'h0, led}, 32'h0);
      chk("rst_mid_q", q_dmem, 32'h0);
      reset = 1'b0;
      echo[2] = 1'b0;
      load(32'hF02, rd);
      chk("rst_mid_status", rd, 32'h0);
      load(32'hF12, rd);
      chk("rst_mid_width2", rd, 32'h0);
      store(32'hF01, 32'h4);
      repeat (12) tick();
      echo[2] = 1'b1;
      repeat (15) tick();
      echo[2] = 1'b0;
      repeat (4) tick();
      load(32'hF02, rd);
      chk("ch2_status", rd, 32'h4);
      load(32'hF12, rd);
      chk_rng("ch2_width", rd, 14, 16);

      // Channel 3 with no echo.
      store(32'hF01, 32'h8);
      repeat (40) tick();
      load(32'hF02, rd);
      chk("ch3_status_early", rd, 32'h0);
      repeat (30) tick();
`ifdef SONAR_TIMEOUT_EN
      load(32'hF02, rd);
      chk("to_status", rd, 32'h0008_0008);
      load(32'hF13, rd);
      chk("to_width", rd, 32'h00FF_FFFF);
      load(32'hF02, rd);
      chk("to_status_clr", rd, 32'h0);
`else
      load(32'hF02, rd);
      chk("noto_status", rd, 32'h0);
      chk("noto_trig", {31'h0, trig[3]}, 32'h0);
      echo[3] = 1'b1;
      repeat (8) tick();
      echo[3] = 1'b0;
      repeat (4) tick();
      load(32'hF02, rd);
      chk("noto_status_done", rd, 32'h8);
      load(32'hF13, rd);
      chk_rng("noto_width", rd, 7, 9);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
